// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver
//   Deserializes an LSB-first serial bit stream from the upstream shift stage.
//   A frame is: start bit (0), WIDTH data bits, optional parity bit, stop bit (1).
//   Every received frame is presented on a valid/ready port together with its
//   parity and framing error flags. Frames with errors are still delivered.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   bit_in      serial bit; the idle line is 1
//   bit_en      bit strobe; bit_in is sampled only when 1
//   data_out    received word, stable while data_valid=1
//   data_valid  word available
//   data_ready  consumer accepts the word when data_valid && data_ready
//   parity_err  parity mismatch for the presented word
//   frame_err   stop bit sampled as 0 for the presented word
//   overrun     one-cycle pulse: a completed frame was dropped (held word kept)
//   busy        receiver is not idle
module serial_frame_receiver #(
    parameter int unsigned WIDTH      = 4,
    parameter bit          PARITY_EN  = 1'b1,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_en,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             parity_err,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sreg;
    logic [CNT_W-1:0] cnt;
    logic             perr;
    logic             complete;
    logic             slot_free;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; transitions happen only on strobe cycles
    always_comb begin
        state_next = state;
        complete   = 1'b0;
        if (bit_en) begin
            case (state)
                S_IDLE: begin
                    if (!bit_in) state_next = S_DATA;
                end
                S_DATA: begin
                    if (cnt == CNT_W'(WIDTH - 1))
                        state_next = PARITY_EN ? S_PARITY : S_STOP;
                end
                S_PARITY: begin
                    state_next = S_STOP;
                end
                S_STOP: begin
                    complete   = 1'b1;
                    // A low stop bit means the line is still low; wait for it
                    // to go high before accepting another start bit.
                    state_next = bit_in ? S_IDLE : S_WAIT_IDLE;
                end
                S_WAIT_IDLE: begin
                    if (bit_in) state_next = S_IDLE;
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    // The slot can take a new word if empty or being emptied this very cycle
    assign slot_free = !data_valid || data_ready;

    // Shift register, bit counter and parity capture
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg <= '0;
            cnt  <= '0;
            perr <= 1'b0;
        end else if (bit_en) begin
            case (state)
                S_IDLE: begin
                    cnt  <= '0;
                    perr <= 1'b0;
                end
                S_DATA: begin
                    sreg <= {bit_in, sreg[WIDTH-1:1]};
                    cnt  <= cnt + CNT_W'(1);
                end
                S_PARITY: begin
                    perr <= ((^sreg) ^ bit_in) != PARITY_ODD;
                end
                default: ;
            endcase
        end
    end

    // Output slot with valid/ready handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (complete) begin
                if (slot_free) begin
                    data_out   <= sreg;
                    parity_err <= perr;
                    frame_err  <= !bit_in;
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
                parity_err <= 1'b0;
                frame_err  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Testbench for serial_frame_receiver (WIDTH=4, even parity enabled).
module tb_serial_frame_receiver;

    logic       clk;
    logic       rst;
    logic       bit_in;
    logic       bit_en;
    logic [3:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    serial_frame_receiver #(
        .WIDTH     (4),
        .PARITY_EN (1'b1),
        .PARITY_ODD(1'b0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bit_in    (bit_in),
        .bit_en    (bit_en),
        .data_out  (data_out),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks;
    int unsigned n_fail;

    // Reference model of the output slot (transaction level)
    logic       mv;
    logic [3:0] mword;
    logic       mpe;
    logic       mfe;
    logic       movr;

    typedef struct {
        logic [3:0] data;
        logic       pbit;
        logic       sbit;
        logic [3:0] exp_data;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic rdyv(input int unsigned m, input bit is_stop);
        case (m)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return 1'($urandom % 2);
            default: return is_stop;
        endcase
    endfunction

    // One clock: drive inputs, update model at the edge, compare 1 time unit later.
    task automatic tick(input logic b, input logic en, input logic rdy, input logic cmp,
                        input logic [3:0] w, input logic pe, input logic fe);
        bit_in     = b;
        bit_en     = en;
        data_ready = rdy;
        @(posedge clk);
        movr = 1'b0;
        if (cmp) begin
            if (!mv || rdy) begin
                mv    = 1'b1;
                mword = w;
                mpe   = pe;
                mfe   = fe;
            end else begin
                movr = 1'b1;
            end
        end else if (mv && rdy) begin
            mv  = 1'b0;
            mpe = 1'b0;
            mfe = 1'b0;
        end
        #1;
        check("data_valid", data_valid, mv);
        check("overrun", overrun, movr);
        if (mv) begin
            check("data_out", data_out, mword);
            check("parity_err", parity_err, mpe);
            check("frame_err", frame_err, mfe);
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        bit_en     = 1'b0;
        bit_in     = 1'b1;
        data_ready = 1'b0;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        mv   = 1'b0;
        mpe  = 1'b0;
        mfe  = 1'b0;
        movr = 1'b0;
        check("rst data_out", data_out, 4'h0);
        check("rst data_valid", data_valid, 1'b0);
        check("rst parity_err", parity_err, 1'b0);
        check("rst frame_err", frame_err, 1'b0);
        check("rst overrun", overrun, 1'b0);
        check("rst busy", busy, 1'b0);
    endtask

    // gmode: 0 no gaps, 1 one idle strobe before each bit, 2 random 0..2 gaps
    // rmode: 0 ready low, 1 ready high, 2 random, 3 high only on the stop strobe
    task automatic send_frame(input logic [3:0] d, input logic pb, input logic sb,
                              input int unsigned gmode, input int unsigned rmode);
        logic [6:0]  bits;
        logic        pe;
        logic        fe;
        int unsigned gaps;
        bits = {sb, pb, d, 1'b0};
        pe   = ((($countones(d) + int'(pb)) % 2) != 0);
        fe   = !sb;
        for (int i = 0; i < 7; i++) begin
            gaps = (gmode == 0) ? 0 : (gmode == 1) ? 1 : $urandom % 3;
            for (int g = 0; g < int'(gaps); g++)
                tick(1'($urandom % 2), 1'b0, rdyv(rmode, 1'b0), 1'b0, 4'h0, 1'b0, 1'b0);
            tick(bits[i], 1'b1, rdyv(rmode, i == 6), i == 6, d, pe, fe);
            if (i == 0) check("busy after start", busy, 1'b1);
            if (i == 6) check("busy after stop", busy, !sb);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        bit_in     = 1'b1;
        bit_en     = 1'b0;
        data_ready = 1'b0;

        tbl[0] = '{4'hB, 1'b1, 1'b1, 4'hB, 1'b0, 1'b0};
        tbl[1] = '{4'hB, 1'b0, 1'b1, 4'hB, 1'b1, 1'b0};
        tbl[2] = '{4'hB, 1'b1, 1'b0, 4'hB, 1'b0, 1'b1};
        tbl[3] = '{4'h5, 1'b0, 1'b1, 4'h5, 1'b0, 1'b0};
        tbl[4] = '{4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0};
        tbl[5] = '{4'hF, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0};
        tbl[6] = '{4'hF, 1'b1, 1'b1, 4'hF, 1'b1, 1'b0};
        tbl[7] = '{4'h7, 1'b0, 1'b1, 4'h7, 1'b1, 1'b0};
        tbl[8] = '{4'h7, 1'b1, 1'b0, 4'h7, 1'b0, 1'b1};
        tbl[9] = '{4'h8, 1'b0, 1'b0, 4'h8, 1'b1, 1'b1};

        do_reset();

        // Table of single frames, word held until explicitly accepted
        for (int i = 0; i < 10; i++) begin
            send_frame(tbl[i].data, tbl[i].pbit, tbl[i].sbit, 0, 0);
            check("tbl data_valid", data_valid, 1'b1);
            check("tbl data_out", data_out, tbl[i].exp_data);
            check("tbl parity_err", parity_err, tbl[i].exp_pe);
            check("tbl frame_err", frame_err, tbl[i].exp_fe);
            tick(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
            check("tbl accepted", data_valid, 1'b0);
            check("tbl idle", busy, 1'b0);
        end

        // Low stop bit followed by a held-low line, then a clean frame
        send_frame(4'hB, 1'b1, 1'b0, 0, 0);
        check("lowrun frame_err", frame_err, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
            check("lowrun busy", busy, 1'b1);
        end
        tick(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        check("lowrun released", busy, 1'b0);
        send_frame(4'h5, 1'b0, 1'b1, 0, 0);
        check("after lowrun data", data_out, 4'h5);
        check("after lowrun ferr", frame_err, 1'b0);
        tick(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);

        // Overrun: second back-to-back frame dropped while the first is held
        send_frame(4'h3, 1'b0, 1'b1, 0, 0);
        send_frame(4'hC, 1'b0, 1'b1, 0, 0);
        check("overrun pulse", overrun, 1'b1);
        check("overrun held word", data_out, 4'h3);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        check("overrun one cycle", overrun, 1'b0);
        tick(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        check("overrun drained", data_valid, 1'b0);

        // Reset in the middle of a frame
        tick(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        do_reset();
        send_frame(4'h9, 1'b0, 1'b1, 0, 0);
        check("post-reset data", data_out, 4'h9);
        check("post-reset perr", parity_err, 1'b0);

        // Strobe gaps, then accept and reload on the same cycle
        tick(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        send_frame(4'h6, 1'b0, 1'b1, 1, 0);
        check("gapped data", data_out, 4'h6);
        check("gapped perr", parity_err, 1'b0);
        send_frame(4'hA, 1'b0, 1'b1, 0, 3);
        check("reload valid", data_valid, 1'b1);
        check("reload data", data_out, 4'hA);
        tick(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);

        // Randomized frames against the model
        for (int k = 0; k < 300; k++) begin
            logic [3:0] d;
            logic       pb;
            logic       sb;
            d  = 4'($urandom);
            pb = 1'($urandom);
            sb = ($urandom % 4) != 0;
            send_frame(d, pb, sb, 2, 2);
            if (!sb) begin
                for (int j = 0; j < int'($urandom % 4); j++) begin
                    tick(1'b0, 1'b1, 1'($urandom % 2), 1'b0, 4'h0, 1'b0, 1'b0);
                    check("rand lowrun busy", busy, 1'b1);
                end
                tick(1'b1, 1'b1, 1'($urandom % 2), 1'b0, 4'h0, 1'b0, 1'b0);
            end
            for (int j = 0; j < int'($urandom % 3); j++)
                tick(1'b1, 1'($urandom % 2), 1'($urandom % 2), 1'b0, 4'h0, 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
